// File: rtl/qarctan_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : GLOBALS (package)
//  Brief    : Shared types and defaults for the qarctan scheduler slice.
//  Revision : 1.0 - initial release
// ============================================================================
package GLOBALS;

  // Default operand / angle width used by the scheduler and its users
  localparam int DEFAULT_DATA_WIDTH = 32;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_WRITE = 2'd3
  } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/qarctan_scheduler_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter
//  Brief    : Combinational cyclic-priority search. Returns the first
//             eligible requester strictly after last_grant, wrapping around.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  eligible,
  input  logic [IDX_W-1:0] last_grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  // Walk offsets from farthest to nearest so the nearest eligible one wins
  always_comb begin
    int idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NREQ;
      if (eligible[idx]) begin
        grant_valid = 1'b1;
        grant_idx   = idx[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/qarctan_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : qarctan_scheduler
//  Brief    : Round-robin sharing of one multi-cycle qarctan engine between
//             NREQ channels fed by FWFT y/x FIFOs; results are pushed into
//             the granted channel's output FIFO.
//  Revision : 1.0 - initial release
// ============================================================================
module qarctan_scheduler
  import GLOBALS::*;
#(
  parameter int NREQ       = 2,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                       clock,
  input  logic                       reset,
  output logic [NREQ-1:0]            y_rd_en,
  input  logic [NREQ-1:0]            y_empty,
  input  logic [NREQ*DATA_WIDTH-1:0] y_dout,
  output logic [NREQ-1:0]            x_rd_en,
  input  logic [NREQ-1:0]            x_empty,
  input  logic [NREQ*DATA_WIDTH-1:0] x_dout,
  output logic [NREQ-1:0]            out_wr_en,
  input  logic [NREQ-1:0]            out_full,
  output logic [DATA_WIDTH-1:0]      out_din,
  output logic                       eng_start,
  output logic [DATA_WIDTH-1:0]      eng_y,
  output logic [DATA_WIDTH-1:0]      eng_x,
  input  logic                       eng_done,
  input  logic [DATA_WIDTH-1:0]      eng_angle,
  output logic                       err_spurious_done
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NREQ - 1);

  sched_state_t          state_q, state_d;
  logic [IDX_W-1:0]      last_grant_q, last_grant_d;
  logic [IDX_W-1:0]      grant_q, grant_d;
  logic [DATA_WIDTH-1:0] op_y_q, op_y_d;
  logic [DATA_WIDTH-1:0] op_x_q, op_x_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] y_word [NREQ];
  logic [DATA_WIDTH-1:0] x_word [NREQ];
  logic [NREQ-1:0]       eligible;
  logic                  arb_valid;
  logic [IDX_W-1:0]      arb_idx;

  // Split the flat head-word buses and form per-channel eligibility
  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign y_word[i]   = y_dout[i*DATA_WIDTH +: DATA_WIDTH];
    assign x_word[i]   = x_dout[i*DATA_WIDTH +: DATA_WIDTH];
    assign eligible[i] = !y_empty[i] && !x_empty[i] && !out_full[i];
  end

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .eligible    (eligible),
    .last_grant  (last_grant_q),
    .grant_valid (arb_valid),
    .grant_idx   (arb_idx)
  );

  // Next-state and datapath register updates
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    op_y_d       = op_y_q;
    op_x_d       = op_x_q;
    result_d     = result_q;
    err_d        = err_q;

    // A done pulse is only meaningful while waiting on the engine
    if (eng_done && (state_q != ST_WAIT)) begin
      err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (arb_valid) begin
          grant_d      = arb_idx;
          last_grant_d = arb_idx;
          op_y_d       = y_word[arb_idx];
          op_x_d       = x_word[arb_idx];
          state_d      = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          result_d = eng_angle;
          state_d  = ST_WRITE;
        end
      end
      ST_WRITE: begin
        // Output FIFO may have filled from elsewhere; stall rather than drop
        if (!out_full[grant_q]) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM and datapath registers; reset discards any in-flight transaction
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= LAST_IDX;
      grant_q      <= '0;
      op_y_q       <= '0;
      op_x_q       <= '0;
      result_q     <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      op_y_q       <= op_y_d;
      op_x_q       <= op_x_d;
      result_q     <= result_d;
      err_q        <= err_d;
    end
  end

  // Strobes decoded from state; pops use the live grant so they land in IDLE
  always_comb begin
    y_rd_en   = '0;
    x_rd_en   = '0;
    out_wr_en = '0;
    out_din   = '0;
    if (!reset && (state_q == ST_IDLE) && arb_valid) begin
      y_rd_en[arb_idx] = 1'b1;
      x_rd_en[arb_idx] = 1'b1;
    end
    if (!reset && (state_q == ST_WRITE) && !out_full[grant_q]) begin
      out_wr_en[grant_q] = 1'b1;
      out_din            = result_q;
    end
  end

  assign eng_start         = !reset && (state_q == ST_ISSUE);
  assign eng_y             = op_y_q;
  assign eng_x             = op_x_q;
  assign err_spurious_done = err_q;

endmodule
`default_nettype wire
